// File: rtl/tcm_arbiter_pkg.sv
// Shared types for the TCM arbiter: port identifiers, the muxed request bundle, byte-select constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tcm_arb_pkg;

    typedef enum logic {
        PORT_INS = 1'b0,
        PORT_DAT = 1'b1
    } tcm_port_t;

    // The request bundle carries a full-width address.
    // The top trims it to MEM_ADDR_WIDTH.
    localparam int TCM_AW_MAX = 32;

    localparam logic [3:0] BSEL_ALL = 4'hF;

    typedef struct packed {
        logic [TCM_AW_MAX-1:0] addr;
        logic [3:0]            bsel;
        logic                  write;
        logic [31:0]           data;
    } tcm_req_t;

endpackage

// File: rtl/tcm_arbiter_if.sv
// Bus bundle between the core's fetch/data masters, the arbiter and the TCM.
// Latency: n/a (wires only); slave = arbiter view, master = core + TCM view.
// Backpressure: requests are held by the masters until their ack.
interface tcm_arbiter_if #(
    parameter int MEM_ADDR_WIDTH = 8
);
    logic                      i_ins_req;
    logic [MEM_ADDR_WIDTH-1:0] i_ins_addr;
    logic                      o_ins_ack;
    logic [31:0]               o_ins_data;

    logic                      i_dat_req;
    logic [MEM_ADDR_WIDTH-1:0] i_dat_addr;
    logic [3:0]                i_dat_sel;
    logic                      i_dat_write;
    logic [31:0]               i_dat_data;
    logic                      o_dat_ack;
    logic [31:0]               o_dat_data;

    logic                      o_tcm_sel;
    logic [MEM_ADDR_WIDTH-1:0] o_tcm_addr;
    logic [3:0]                o_tcm_bsel;
    logic                      o_tcm_write;
    logic [31:0]               o_tcm_data;
    logic                      i_tcm_ack;
    logic [31:0]               i_tcm_data;

    modport slave (
        input  i_ins_req, i_ins_addr,
        output o_ins_ack, o_ins_data,
        input  i_dat_req, i_dat_addr, i_dat_sel, i_dat_write, i_dat_data,
        output o_dat_ack, o_dat_data,
        output o_tcm_sel, o_tcm_addr, o_tcm_bsel, o_tcm_write, o_tcm_data,
        input  i_tcm_ack, i_tcm_data
    );

    modport master (
        output i_ins_req, i_ins_addr,
        input  o_ins_ack, o_ins_data,
        output i_dat_req, i_dat_addr, i_dat_sel, i_dat_write, i_dat_data,
        input  o_dat_ack, o_dat_data,
        input  o_tcm_sel, o_tcm_addr, o_tcm_bsel, o_tcm_write, o_tcm_data,
        output i_tcm_ack, i_tcm_data
    );
endinterface

// File: rtl/tcm_arbiter_pick.sv
// Grant policy: picks the winning port from the eligible pair (round-robin when TCM_ARB_RR_EN, else dat first).
// Latency: combinational.
// Backpressure: none; a loser simply stays eligible next cycle.
module tcm_arb_pick
    import tcm_arb_pkg::*;
(
    input  logic      elig_ins,
    input  logic      elig_dat,
    input  tcm_port_t last,
    output tcm_port_t winner
);

`ifndef TCM_ARB_RR_EN
    // Fixed priority has no use for the previous winner.
    logic unused_last;
    assign unused_last = last;
`endif

    // Resolve a tie by policy; a single eligible port always wins.
    always_comb begin
        winner = PORT_INS;
        if (elig_ins && elig_dat) begin
`ifdef TCM_ARB_RR_EN
            winner = (last == PORT_DAT) ? PORT_INS : PORT_DAT;
`else
            winner = PORT_DAT;
`endif
        end else if (elig_dat) begin
            winner = PORT_DAT;
        end
    end

endmodule

// File: rtl/tcm_arbiter.sv
// Shares the single-port TCM between instruction fetch and data; optional round-robin via macro TCM_ARB_RR_EN.
// Latency: grant is combinational, ack and read data return one cycle after grant.
// Backpressure: the losing or pending port keeps its request held; the pending port is masked for one cycle.
module tcm_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    tcm_arbiter_if.slave   bus
);

    logic      r_pend_valid;
    tcm_port_t r_pend_id;
    tcm_port_t r_last;
    tcm_port_t winner;
    logic      elig_ins;
    logic      elig_dat;
    logic      grant;
    tcm_req_t  req;

    // A port whose transaction is in its ack cycle must not be re-issued.
    assign elig_ins = bus.i_ins_req & ~(r_pend_valid & (r_pend_id == PORT_INS));
    assign elig_dat = bus.i_dat_req & ~(r_pend_valid & (r_pend_id == PORT_DAT));

    // Reset forces every TCM-side output low even with requests held.
    assign grant = (elig_ins | elig_dat) & ~i_reset;

    tcm_arb_pick u_pick (
        .elig_ins (elig_ins),
        .elig_dat (elig_dat),
        .last     (r_last),
        .winner   (winner)
    );

    // Mux the winning requester onto the TCM; fetches are full-word reads.
    always_comb begin
        req = '0;
        if (grant) begin
            if (winner == PORT_DAT) begin
                req.addr  = TCM_AW_MAX'(bus.i_dat_addr);
                req.bsel  = bus.i_dat_sel;
                req.write = bus.i_dat_write;
                req.data  = bus.i_dat_data;
            end else begin
                req.addr  = TCM_AW_MAX'(bus.i_ins_addr);
                req.bsel  = BSEL_ALL;
                req.write = 1'b0;
                req.data  = '0;
            end
        end
    end

    assign bus.o_tcm_sel   = grant;
    assign bus.o_tcm_addr  = req.addr[MEM_ADDR_WIDTH-1:0];
    assign bus.o_tcm_bsel  = req.bsel;
    assign bus.o_tcm_write = req.write;
    assign bus.o_tcm_data  = req.data;

    // Track who owns the access now on the TCM; rewritten every cycle for back-to-back issue.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pend_valid <= 1'b0;
            r_pend_id    <= PORT_INS;
        end else begin
            r_pend_valid <= grant;
            r_pend_id    <= winner;
        end
    end

`ifdef TCM_ARB_RR_EN
    // Remember the last winner so a tie goes to the other port.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last <= PORT_INS;
        end else if (grant) begin
            r_last <= winner;
        end
    end
`else
    assign r_last = PORT_INS;
`endif

    // Route the TCM ack only to the owner; stray acks with nothing pending are dropped.
    assign bus.o_ins_ack  = bus.i_tcm_ack & r_pend_valid & (r_pend_id == PORT_INS);
    assign bus.o_dat_ack  = bus.i_tcm_ack & r_pend_valid & (r_pend_id == PORT_DAT);
    assign bus.o_ins_data = bus.o_ins_ack ? bus.i_tcm_data : 32'h0;
    assign bus.o_dat_data = bus.o_dat_ack ? bus.i_tcm_data : 32'h0;

endmodule

// File: tb/tb_tcm_arbiter.sv
// Bench for tcm_arbiter: cycle table of requests with expected grants, ack scoreboard, reset and stray-ack sequences.
// Latency checked: grant same cycle, ack next cycle.
// Backpressure: requesters hold until ack, as the table encodes.
module tb_tcm_arbiter;

    logic clk;
    logic rst;
    logic spur;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_ins_ack = 0;
    int   n_dat_ack = 0;
    logic [31:0] last_ins_data = 32'h0;

    tcm_arbiter_if #(.MEM_ADDR_WIDTH(8)) bus ();

    tcm_arbiter #(.MEM_ADDR_WIDTH(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // TCM model: one-cycle ack, old word returned, byte-enabled writes.
    logic [31:0] mem [256];
    logic        tcm_ack_r;
    logic [31:0] tcm_rd;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            tcm_ack_r <= 1'b0;
            tcm_rd    <= 32'h0;
        end else begin
            tcm_ack_r <= bus.o_tcm_sel;
            tcm_rd    <= mem[bus.o_tcm_addr];
            if (bus.o_tcm_sel && bus.o_tcm_write)
                for (int b = 0; b < 4; b++)
                    if (bus.o_tcm_bsel[b]) mem[bus.o_tcm_addr][8*b +: 8] <= bus.o_tcm_data[8*b +: 8];
        end
    end
    assign bus.i_tcm_ack  = tcm_ack_r | spur;
    assign bus.i_tcm_data = tcm_rd;

    // g: 0 = no grant, 1 = ins, 2 = dat
    typedef struct {
        logic        ir;
        logic [7:0]  ia;
        logic        dr;
        logic [7:0]  da;
        logic [3:0]  ds;
        logic        dw;
        logic [31:0] dd;
        logic [1:0]  g;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    vec_t tv[17];

    function automatic vec_t mk(input logic ir, input logic [7:0] ia, input logic dr, input logic [7:0] da,
                                input logic [3:0] ds, input logic dw, input logic [31:0] dd, input logic [1:0] g);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.ds = ds; v.dw = dw; v.dd = dd; v.g = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.i_ins_req   = v.ir;
        bus.i_ins_addr  = v.ia;
        bus.i_dat_req   = v.dr;
        bus.i_dat_addr  = v.da;
        bus.i_dat_sel   = v.ds;
        bus.i_dat_write = v.dw;
        bus.i_dat_data  = v.dd;
    endtask

    // Compare acks against the scoreboard entry pushed one cycle earlier.
    task automatic check_acks();
        exp_t e;
        logic exp_ia, exp_da;
        logic [31:0] exp_id, exp_dd;
        while (sbq.size() > 0 && sbq[0].cyc < cyc - 1) begin
            e = sbq.pop_front();
            chk("lost_ack", 32'(e.cyc), 32'(cyc - 1));
        end
        exp_ia = 1'b0; exp_da = 1'b0; exp_id = 32'h0; exp_dd = 32'h0;
        if (sbq.size() > 0 && sbq[0].cyc == cyc - 1) begin
            e = sbq.pop_front();
            if (e.port) begin exp_da = 1'b1; exp_dd = e.data; end
            else        begin exp_ia = 1'b1; exp_id = e.data; end
        end
        chk("ins_ack",  32'(bus.o_ins_ack), 32'(exp_ia));
        chk("dat_ack",  32'(bus.o_dat_ack), 32'(exp_da));
        chk("ins_data", bus.o_ins_data, exp_id);
        chk("dat_data", bus.o_dat_data, exp_dd);
        n_ins_ack += int'(bus.o_ins_ack);
        n_dat_ack += int'(bus.o_dat_ack);
        if (bus.o_ins_ack) last_ins_data = bus.o_ins_data;
    endtask

    // Apply one table row: called just after a rising edge, returns just after the next one.
    task automatic run_vec(input vec_t v);
        logic        e_sel, e_wr;
        logic [7:0]  e_addr;
        logic [3:0]  e_bsel;
        logic [31:0] e_data;
        exp_t        e;
        drive(v);
        @(negedge clk);
        e_sel = 1'b0; e_addr = 8'h0; e_bsel = 4'h0; e_wr = 1'b0; e_data = 32'h0;
        if (v.g == 2'd1) begin
            e_sel = 1'b1; e_addr = v.ia; e_bsel = 4'hF;
        end else if (v.g == 2'd2) begin
            e_sel = 1'b1; e_addr = v.da; e_bsel = v.ds; e_wr = v.dw; e_data = v.dd;
        end
        chk("tcm_sel",   32'(bus.o_tcm_sel),   32'(e_sel));
        chk("tcm_addr",  32'(bus.o_tcm_addr),  32'(e_addr));
        chk("tcm_bsel",  32'(bus.o_tcm_bsel),  32'(e_bsel));
        chk("tcm_write", 32'(bus.o_tcm_write), 32'(e_wr));
        chk("tcm_data",  bus.o_tcm_data,       e_data);
        check_acks();
        if (v.g != 2'd0) begin
            e.port = (v.g == 2'd2);
            e.data = mem[e_addr];
            e.cyc  = cyc;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},      32'(bus.o_tcm_sel),   32'h0);
        chk({tag, "_addr"},     32'(bus.o_tcm_addr),  32'h0);
        chk({tag, "_bsel"},     32'(bus.o_tcm_bsel),  32'h0);
        chk({tag, "_write"},    32'(bus.o_tcm_write), 32'h0);
        chk({tag, "_wdata"},    bus.o_tcm_data,       32'h0);
        chk({tag, "_ins_ack"},  32'(bus.o_ins_ack),   32'h0);
        chk({tag, "_dat_ack"},  32'(bus.o_dat_ack),   32'h0);
        chk({tag, "_ins_data"}, bus.o_ins_data,       32'h0);
        chk({tag, "_dat_data"}, bus.o_dat_data,       32'h0);
    endtask

    initial begin
        // Fetch of 0x10, then data write, then fetch reading the written word back.
        tv[0] = mk(1, 8'h10, 0, 8'h00, 4'h0, 0, 32'h0, 2'd1);
        tv[1] = mk(1, 8'h10, 0, 8'h00, 4'h0, 0, 32'h0, 2'd0);
        tv[2] = mk(0, 8'h00, 0, 8'h00, 4'h0, 0, 32'h0, 2'd0);
        tv[3] = mk(0, 8'h00, 1, 8'h04, 4'h3, 1, 32'hDEADBEEF, 2'd2);
        tv[4] = mk(0, 8'h00, 1, 8'h04, 4'h3, 1, 32'hDEADBEEF, 2'd0);
        tv[5] = mk(1, 8'h04, 0, 8'h00, 4'h0, 0, 32'h0, 2'd1);
        tv[6] = mk(1, 8'h04, 0, 8'h00, 4'h0, 0, 32'h0, 2'd0);
        tv[7] = mk(0, 8'h00, 0, 8'h00, 4'h0, 0, 32'h0, 2'd0);
        // Both ports requesting continuously: dat, ins, dat, ins ...
        for (int k = 0; k < 8; k++)
            tv[8 + k] = mk(1, 8'h20, 1, 8'h30, 4'hF, 0, 32'h0, (k % 2 == 0) ? 2'd2 : 2'd1);
        tv[16] = mk(0, 8'h00, 0, 8'h00, 4'h0, 0, 32'h0, 2'd0);

        spur = 1'b0;
        rst  = 1'b1;
        // Requests held high during reset must not reach the TCM.
        drive(mk(1, 8'h55, 1, 8'h66, 4'hF, 1, 32'h12345678, 2'd0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(tv[i]);
        chk("rd_after_wr", last_ins_data, 32'hA500BEEF);

        // Reset asserted while the TCM ack for a pending fetch is in flight.
        run_vec(mk(1, 8'h40, 0, 8'h00, 4'h0, 0, 32'h0, 2'd1));
        rst = 1'b1;
        bus.i_dat_req  = 1'b1;
        bus.i_dat_addr = 8'h41;
        bus.i_dat_sel  = 4'hF;
        @(negedge clk);
        chk("midrst_tcm_ack_seen", 32'(bus.i_tcm_ack), 32'h1);
        chk_all_zero("midrst");
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec(mk(0, 8'h00, 0, 8'h00, 4'h0, 0, 32'h0, 2'd0));

        n_ins_ack = 0;
        n_dat_ack = 0;
        for (int i = 8; i < 17; i++) run_vec(tv[i]);
        chk("alt_ins_acks", 32'(n_ins_ack), 32'd4);
        chk("alt_dat_acks", 32'(n_dat_ack), 32'd4);
        chk("alt_queue_empty", 32'(sbq.size()), 32'd0);

        // Stray TCM ack with nothing pending.
        spur = 1'b1;
        run_vec(mk(0, 8'h00, 0, 8'h00, 4'h0, 0, 32'h0, 2'd0));
        spur = 1'b0;
        run_vec(mk(0, 8'h00, 0, 8'h00, 4'h0, 0, 32'h0, 2'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcm_arbiter.md
Name: tcm_arbiter

Overview:
Two-port arbiter that shares the single-port TCM between the core's instruction-fetch port (read-only) and data port (read/write).
- Sits between the core bus masters and the TCM device-select interface.
- Picks one requester per cycle and drives the TCM address, byte-select, write and data lines combinationally.
- Returns the TCM's one-cycle-late ack and read data only to the requester that owns the transaction.
- Sustains one TCM access per cycle when the two ports alternate.

Parameters:
MEM_ADDR_WIDTH, 8, TCM word-address width; byte address bits [MEM_ADDR_WIDTH+1:2] are carried.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_ins_req  in  1  fetch request; held until o_ins_ack
i_ins_addr  in  MEM_ADDR_WIDTH  fetch word address
o_ins_ack  out  1  fetch complete; o_ins_data valid this cycle
o_ins_data  out  32  fetch read data
i_dat_req  in  1  data request; held until o_dat_ack
i_dat_addr  in  MEM_ADDR_WIDTH  data word address
i_dat_sel  in  4  byte enables
i_dat_write  in  1  1 = write, 0 = read
i_dat_data  in  32  write data
o_dat_ack  out  1  data access complete
o_dat_data  out  32  data read data
o_tcm_sel  out  1  TCM device select
o_tcm_addr  out  MEM_ADDR_WIDTH  TCM word address
o_tcm_bsel  out  4  TCM byte enables
o_tcm_write  out  1  TCM write strobe
o_tcm_data  out  32  TCM write data
i_tcm_ack  in  1  TCM ack; one cycle after select
i_tcm_data  in  32  TCM read data

Behaviour:
- Pending state: r_pend_valid, r_pend_id (0 = ins, 1 = dat). Reset: both 0.
- Eligibility:
  - elig_ins = i_ins_req & ~(r_pend_valid & r_pend_id==0)
  - elig_dat = i_dat_req & ~(r_pend_valid & r_pend_id==1)
  - A port's req in its own ack cycle is the old transaction and is never re-issued.
- Grant (combinational):
  - Default policy is fixed priority, dat over ins.
  - o_tcm_sel = elig_ins | elig_dat.
  - o_tcm_addr, o_tcm_bsel, o_tcm_write, o_tcm_data are muxed from the winner.
  - For an ins grant: bsel = 4'hF, write = 0, data = 0.
  - With no grant, all TCM outputs are 0.
- Pending register, next edge: r_pend_valid <= o_tcm_sel; r_pend_id <= winner. The register is overwritten every cycle, which gives back-to-back pipelining.
- Response:
  - o_ins_ack = i_tcm_ack & r_pend_valid & r_pend_id==0; o_dat_ack likewise for id 1.
  - o_x_data = i_tcm_data when that port is acked, else 0.
- Latency: 1 cycle from grant to ack; an uncontended request acks in the cycle after assertion.
- Throughput:
  - Alternating ports: 1 access per cycle.
  - A single port alone: 1 access per 2 cycles.
  - Both ports continuously requesting: strict alternation, because the eligibility mask bars the pending port.
- Reset mid-transaction: pending is cleared asynchronously. A TCM ack arriving after reset is dropped (no o_*_ack). Outputs are 0 while i_reset is high.
- i_tcm_ack while r_pend_valid = 0: ignored.
- Requesters must hold address and data stable until ack. The arbiter does not register request fields.

Optional Feature:
TCM_ARB_RR_EN
- Defined: round-robin. A register r_last (reset 0) records the last winner. On a simultaneous eligible pair, the port not equal to r_last wins, and r_last updates on every grant.
- Undefined: fixed dat-over-ins priority and no r_last flop. Starvation is still bounded by the eligibility mask.

Decomposition:
- Package tcm_arb_pkg:
  - typedef enum logic {PORT_INS, PORT_DAT} tcm_port_t
  - typedef struct packed {addr, bsel, write, data} tcm_req_t
  - constant BSEL_ALL = 4'hF
- One sub-module, tcm_arb_pick: pure grant logic taking elig_ins, elig_dat and r_last, and returning the winner. It is swappable for the RR and fixed policies.

Test Plan:
- Reset, then i_ins_req=1, addr 0x10 → o_tcm_sel=1, o_tcm_addr=0x10, bsel=F, write=0 in cycle 0; o_ins_ack=1 with TCM word 0x10 in cycle 1; no grant re-issued in cycle 1.
- i_dat_req write, addr 0x04, sel 4'b0011, data 0xDEADBEEF → TCM write at 0x04; o_dat_ack next cycle; a following ins read of 0x04 returns low 16 bits 0xBEEF.
- Both ports requesting continuously for 8 cycles → grants alternate dat, ins, dat, …; 8 acks total, each routed to the correct port, none lost.
- TCM_ARB_RR_EN defined, with the first simultaneous request after reset (r_last=0) → dat wins first. Undefined → dat wins every simultaneous cycle with no pending block.
- Assert i_reset in the cycle after a grant → no o_*_ack in the following cycle despite i_tcm_ack=1; all outputs 0 during reset.
- Spurious i_tcm_ack=1 with no pending transaction → both o_*_ack stay 0.
